// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared pipeline types: forwarding select codes and stage slot struct
package mips_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_slot_t;

    // True when slot s will produce register r; the zero register never produces anything.
    function automatic logic slot_match(input logic [REG_ADDR_W-1:0] r,
                                        input stage_slot_t            s,
                                        input logic [REG_ADDR_W-1:0] zero_idx);
        return s.valid & s.reg_write & (s.rd == r) & (r != zero_idx);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - ID-stage operand info in, EX forwarding selects and stall/bubble out
interface fwd_hazard_ctrl_if;
    import mips_pipe_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic [1:0]            ex_fwd_a;
    logic [1:0]            ex_fwd_b;
    logic                  stall;
    logic                  bubble;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_write, id_mem_read,
        input  ex_fwd_a, ex_fwd_b, stall, bubble
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_write, id_mem_read,
        output ex_fwd_a, ex_fwd_b, stall, bubble
    );

endinterface

// File: rtl/fwd_src_sel.sv
// rtl/fwd_src_sel.sv - priority compare of one source register against EX and MEM producers
module fwd_src_sel
    import mips_pipe_pkg::*;
#(
    parameter logic [REG_ADDR_W-1:0] ZERO_IDX = '0
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  uses,
    input  stage_slot_t           ex_slot,
    input  stage_slot_t           mem_slot,
    output logic [1:0]            sel
);

    // Load flags are irrelevant here; load-use is resolved by stalling in the top.
    logic unused_mem_read;
    assign unused_mem_read = ex_slot.mem_read ^ mem_slot.mem_read;

    always_comb begin
        sel = FWD_REGFILE;
        if (uses) begin
            if (slot_match(src, ex_slot, ZERO_IDX)) begin
                sel = FWD_MEM;
            end else if (slot_match(src, mem_slot, ZERO_IDX)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding select registers and load-use stall control
// Optional FWD_PERF_CNT_EN adds stall and forwarding event counters.
module fwd_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int ZERO_REG = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hold,
    input  logic                flush,
    fwd_hazard_ctrl_if.slave    bus
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_fwd_cnt
`endif
);

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

    stage_slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [1:0]  sel_a, sel_b;
    logic        load_use, advance, kill, stall, bubble;

    // The WB slot is shadow state only: the register file is write-first, so nothing reads it.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    fwd_src_sel #(.ZERO_IDX(ZERO_IDX)) u_sel_a (
        .src(bus.id_rs), .uses(bus.id_uses_rs), .ex_slot(ex_q), .mem_slot(mem_q), .sel(sel_a)
    );

    fwd_src_sel #(.ZERO_IDX(ZERO_IDX)) u_sel_b (
        .src(bus.id_rt), .uses(bus.id_uses_rt), .ex_slot(ex_q), .mem_slot(mem_q), .sel(sel_b)
    );

    always_comb begin
        load_use = bus.id_valid & ex_q.mem_read &
                   ((bus.id_uses_rs & slot_match(bus.id_rs, ex_q, ZERO_IDX)) |
                    (bus.id_uses_rt & slot_match(bus.id_rt, ex_q, ZERO_IDX)));
        advance  = ~hold;
        stall    = advance & load_use & ~flush;
        bubble   = advance & (load_use | flush);
        kill     = bubble | ~bus.id_valid;

        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (advance) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = '0;
            if (!kill) begin
                ex_d.valid     = 1'b1;
                ex_d.rd        = bus.id_rd;
                ex_d.reg_write = bus.id_reg_write;
                ex_d.mem_read  = bus.id_mem_read;
            end
            fwd_a_d = kill ? FWD_REGFILE : sel_a;
            fwd_b_d = kill ? FWD_REGFILE : sel_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_REGFILE;
            fwd_b_q <= FWD_REGFILE;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign bus.ex_fwd_a = fwd_a_q;
    assign bus.ex_fwd_b = fwd_b_q;
    assign bus.stall    = stall;
    assign bus.bubble   = bubble;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        fwd_cnt_d   = fwd_cnt_q;
        if (advance && (fwd_a_d != FWD_REGFILE || fwd_b_d != FWD_REGFILE)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - scoreboard bench for fwd_hazard_ctrl with directed MIPS sequences
module tb_fwd_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    typedef struct {
        int         step;
        logic [5:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   step = 0;
    sb_t  sb[$];

    fwd_hazard_ctrl_if bus ();

`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_fwd_cnt;
    fwd_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .bus(bus.slave),
        .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
    );
`else
    fwd_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .bus(bus.slave)
    );
`endif

    always #5 clk = ~clk;

    function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        ins_t i;
        i = '0;
        i.valid = 1'b1; i.rs = rs; i.rt = rt; i.urs = 1'b1; i.urt = 1'b1; i.rd = rd; i.rw = 1'b1;
        return i;
    endfunction

    function automatic ins_t lw(input logic [4:0] rd, input logic [4:0] base);
        ins_t i;
        i = '0;
        i.valid = 1'b1; i.rs = base; i.urs = 1'b1; i.rd = rd; i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    localparam ins_t NOP = '0;

    task automatic cyc(input logic rst_v, input logic hold_v, input logic flush_v, input ins_t ins,
                       input logic [1:0] ea, input logic [1:0] eb, input logic es, input logic ebv);
        sb_t e;
        @(posedge clk);
        #1;
        rst_n            = rst_v;
        hold             = hold_v;
        flush            = flush_v;
        bus.id_valid     = ins.valid;
        bus.id_rs        = ins.rs;
        bus.id_rt        = ins.rt;
        bus.id_uses_rs   = ins.urs;
        bus.id_uses_rt   = ins.urt;
        bus.id_rd        = ins.rd;
        bus.id_reg_write = ins.rw;
        bus.id_mem_read  = ins.mr;
        e.step = step;
        e.exp  = {ea, eb, es, ebv};
        sb.push_back(e);
        step++;
    endtask

    task automatic go(input ins_t ins, input logic [1:0] ea, input logic [1:0] eb,
                      input logic es, input logic ebv);
        cyc(1'b1, 1'b0, 1'b0, ins, ea, eb, es, ebv);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t        e;
            logic [5:0] act;
            e   = sb.pop_front();
            act = {bus.ex_fwd_a, bus.ex_fwd_b, bus.stall, bus.bubble};
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL step%0d: got a=%b b=%b stall=%b bubble=%b, want a=%b b=%b stall=%b bubble=%b",
                         e.step, act[5:4], act[3:2], act[1], act[0],
                         e.exp[5:4], e.exp[3:2], e.exp[1], e.exp[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 1'b0;
        bus.id_uses_rt = 1'b0; bus.id_rd = '0; bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0;

        // reset state
        cyc(1'b0, 1'b0, 1'b0, NOP, 2'b00, 2'b00, 1'b0, 1'b0);

        // addu $3,$1,$2 ; addu $4,$3,$3 -> both from MEM
        go(alu(3, 1, 2), 2'b00, 2'b00, 1'b0, 1'b0);
        go(alu(4, 3, 3), 2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b10, 2'b10, 1'b0, 1'b0);
        go(NOP,          2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b00, 2'b00, 1'b0, 1'b0);

        // addu $3 ; nop ; subu $5,$3,$6 -> A from WB
        go(alu(3, 1, 2), 2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b00, 2'b00, 1'b0, 1'b0);
        go(alu(5, 3, 6), 2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b01, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b00, 2'b00, 1'b0, 1'b0);

        // lw $7 ; addu $8,$7,$1 -> one stall, then A from WB
        go(lw(7, 1),     2'b00, 2'b00, 1'b0, 1'b0);
        go(alu(8, 7, 1), 2'b00, 2'b00, 1'b1, 1'b1);
        go(alu(8, 7, 1), 2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b01, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b00, 2'b00, 1'b0, 1'b0);
`ifdef FWD_PERF_CNT_EN
        total++;
        if (perf_stall_cnt !== 32'd1) begin
            bad++;
            $display("FAIL perf_stall_cnt: got %0d want 1", perf_stall_cnt);
        end
        total++;
        if (perf_fwd_cnt !== 32'd3) begin
            bad++;
            $display("FAIL perf_fwd_cnt: got %0d want 3", perf_fwd_cnt);
        end
`endif

        // $0 never forwarded, lw $0 never a hazard
        go(alu(0, 1, 2), 2'b00, 2'b00, 1'b0, 1'b0);
        go(alu(4, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b00, 2'b00, 1'b0, 1'b0);
        go(lw(0, 1),     2'b00, 2'b00, 1'b0, 1'b0);
        go(alu(9, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,          2'b00, 2'b00, 1'b0, 1'b0);

        // flush with load-use pending: bubble only, killed instr leaves EX empty
        go(lw(7, 1),                                    2'b00, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, alu(8, 7, 1),             2'b00, 2'b00, 1'b0, 1'b1);
        go(alu(10, 8, 8),                               2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,                                         2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,                                         2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,                                         2'b00, 2'b00, 1'b0, 1'b0);

        // hold across a load-use, then hold with a live WB select
        go(lw(7, 1),                                    2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, alu(8, 7, 1),         2'b00, 2'b00, 1'b0, 1'b0);
        end
        go(alu(8, 7, 1),                                2'b00, 2'b00, 1'b1, 1'b1);
        go(alu(8, 7, 1),                                2'b00, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, NOP,                      2'b01, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, NOP,                      2'b01, 2'b00, 1'b0, 1'b0);
        go(NOP,                                         2'b01, 2'b00, 1'b0, 1'b0);
        go(NOP,                                         2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,                                         2'b00, 2'b00, 1'b0, 1'b0);

        // reset pulse during a stall with a nonzero select showing
        go(alu(3, 1, 2),                                2'b00, 2'b00, 1'b0, 1'b0);
        go(lw(7, 3),                                    2'b00, 2'b00, 1'b0, 1'b0);
        go(alu(8, 7, 1),                                2'b10, 2'b00, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, alu(8, 7, 1),             2'b00, 2'b00, 1'b0, 1'b0);
        go(NOP,                                         2'b00, 2'b00, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
